cordic_input_stage: RTL and testbench
=====================================

// Module: cordic_input_stage
//
// PURPOSE
// Front end of the CORDIC vectoring core. Accepts (x,y) operands over a valid/ready
// handshake, buffers up to FIFO_DEPTH of them, applies quadrant pre-rotation so the
// core always sees x >= 0, then issues a one-cycle start to the control unit. It holds
// x0/y0/z0 stable until the core has finished and returned to IDLE.
//
// PARAMETERS
// DATA_WIDTH   16  signed two's-complement width of x, y
// ANGLE_WIDTH  16  signed angle width; full scale +/-pi, so pi/2 = 2^(ANGLE_WIDTH-2)
// FIFO_DEPTH   2   operand buffer entries (power of 2, >= 2)
//
// PORTS
// clk        in   1            clock, rising edge
// rst        in   1            asynchronous reset, active-low
// in_valid   in   1            operand pair present on in_x/in_y
// in_ready   out  1            buffer can accept; transfer when in_valid & in_ready
// in_x       in   DATA_WIDTH   signed x operand
// in_y       in   DATA_WIDTH   signed y operand
// core_done  in   1            control unit done (high in its IDLE and FINAL states)
// core_start out  1            one-cycle start pulse to control unit
// x0         out  DATA_WIDTH   pre-rotated x seed for datapath (always >= 0)
// y0         out  DATA_WIDTH   pre-rotated y seed
// z0         out  ANGLE_WIDTH  initial angle accumulator seed
// busy       out  1            high while an operand is in flight through the core
//
// BEHAVIOUR
// - Reset: FIFO emptied, state READY, core_start=0, x0=y0=z0=0, busy=0; in_ready=1
//   from the first cycle after reset release. Reset mid-operation discards all
//   buffered and in-flight operands with no pulses emitted.
// - FIFO: in_ready = !full (registered count, no combinational path from core_done).
//   Push and pop in the same cycle are legal at any non-full occupancy.
//   Count wraps pointers mod FIFO_DEPTH; overflow is impossible by construction.
// - Pre-rotation (applied at pop, registered into x0/y0/z0):
//   x>=0:          x0=x,  y0=y,  z0=0
//   x<0, y>=0:     x0=y,  y0=-x, z0=+pi/2 (0x4000 @16b)
//   x<0, y<0:      x0=-y, y0=x,  z0=-pi/2 (0xC000 @16b)
//   Negation saturates: -(-2^(DATA_WIDTH-1)) -> 2^(DATA_WIDTH-1)-1.
// - FSM (4 states):
//   READY: busy=0. If FIFO non-empty: pop, load x0/y0/z0, assert core_start next
//          cycle, -> ARMED.
//   ARMED: core_start=1 for exactly this one cycle; -> BUSY when core_done==0
//          (core entered COMPUTE), else remain (core_start deasserted after 1st cycle).
//   BUSY:  wait for core_done==1 (core in FINAL) -> DRAIN.
//   DRAIN: one cycle while core moves FINAL->IDLE (a start here would be lost);
//          -> READY.
// - busy=1 in ARMED/BUSY/DRAIN. x0/y0/z0 change only on a READY pop.
// - Latency: input accepted at edge N with empty FIFO and READY -> pop at N+1,
//   x0 valid and core_start high at N+2. Back-to-back issue spacing =
//   ITERATIONS + 4 cycles.
//
// STRUCTURE
// - Shared package: ANGLE_PI_2 / ANGLE_NEG_PI_2 constants (derived from
//   ANGLE_WIDTH), FSM state encoding (2-bit), saturating negate function.
// - One sub-module: cordic_operand_fifo (sync FIFO, DATA_WIDTH*2 wide, FIFO_DEPTH
//   entries, push/pop/full/empty). Pre-rotation and FSM stay in the top.
//
// TESTING
// - Reset: rst low mid-BUSY with 2 entries buffered -> next cycle busy=0,
//   core_start=0, x0/y0/z0=0; after release in_ready=1, no start pulse issued.
// - Quadrants (16b): (100,50)->(100,50,0); (-100,50)->(50,100,0x4000);
//   (-100,-50)->(50,-100,0xC000); (0,-7)->(0,-7,0).
// - Saturation: (-32768,0)->x0=0,y0=32767,z0=0x4000; (-1,-32768)->x0=32767,y0=-1.
// - Handshake: hold in_valid=1 for 4 operands with core model stalled -> exactly
//   2 accepted plus 1 in flight, in_ready=0 thereafter; order preserved on issue.
// - Core model (ITERATIONS=16): each core_start exactly 1 cycle, never asserted
//   while core_done=0 or core in FINAL; back-to-back starts spaced 20 cycles.
// - Simultaneous push/pop at occupancy 1 during READY pop -> count unchanged,
//   next issued operand is the older entry.

Source files
------------

// File: rtl/cordic_input_stage_pkg.sv
// Shared definitions for the CORDIC vectoring front end: FSM encoding,
// angle constants derived from the angle width, and saturating negation.
package cordic_input_stage_pkg;

    localparam int DATA_WIDTH_DEF  = 16;
    localparam int ANGLE_WIDTH_DEF = 16;
    localparam int FIFO_DEPTH_DEF  = 2;

    typedef enum logic [1:0] {
        ST_READY = 2'd0,
        ST_ARMED = 2'd1,
        ST_BUSY  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    // Full scale is +/-pi, so pi/2 sits two bits below the sign bit.
    function automatic logic signed [31:0] angle_pi_2(input int w);
        return 32'sd1 <<< (w - 2);
    endfunction

    function automatic logic signed [31:0] angle_neg_pi_2(input int w);
        return -(32'sd1 <<< (w - 2));
    endfunction

    // Negate a sign-extended w-bit value; the most negative code maps to max.
    function automatic logic signed [31:0] sat_neg(input logic signed [31:0] v, input int w);
        logic signed [31:0] v_max;
        v_max = (32'sd1 <<< (w - 1)) - 32'sd1;
        if (v < -v_max) begin
            return v_max;
        end
        return -v;
    endfunction

endpackage

// File: rtl/cordic_operand_fifo.sv
// Synchronous operand FIFO; pushes while full and pops while empty are ignored.
module cordic_operand_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_dout  = r_mem[r_rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_din;
    end

endmodule

// File: rtl/cordic_input_stage.sv
// CORDIC vectoring front end: buffers operands, pre-rotates into the right
// half-plane, and sequences one start pulse per operand against the core.
module cordic_input_stage
    import cordic_input_stage_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int ANGLE_WIDTH = ANGLE_WIDTH_DEF,
    parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic signed [DATA_WIDTH-1:0]  in_x,
    input  logic signed [DATA_WIDTH-1:0]  in_y,
    input  logic                          core_done,
    output logic                          core_start,
    output logic signed [DATA_WIDTH-1:0]  x0,
    output logic signed [DATA_WIDTH-1:0]  y0,
    output logic signed [ANGLE_WIDTH-1:0] z0,
    output logic                          busy
);

    localparam logic signed [ANGLE_WIDTH-1:0] L_PI_2     = ANGLE_WIDTH'(angle_pi_2(ANGLE_WIDTH));
    localparam logic signed [ANGLE_WIDTH-1:0] L_NEG_PI_2 = ANGLE_WIDTH'(angle_neg_pi_2(ANGLE_WIDTH));

    state_t                          r_state;
    state_t                          w_state_nxt;
    logic                            w_push;
    logic                            w_pop;
    logic                            w_fifo_full;
    logic                            w_fifo_empty;
    logic [2*DATA_WIDTH-1:0]         w_fifo_dout;
    logic signed [DATA_WIDTH-1:0]    w_pop_x;
    logic signed [DATA_WIDTH-1:0]    w_pop_y;
    logic signed [DATA_WIDTH-1:0]    w_rot_x;
    logic signed [DATA_WIDTH-1:0]    w_rot_y;
    logic signed [ANGLE_WIDTH-1:0]   w_rot_z;
    logic signed [DATA_WIDTH-1:0]    r_x0;
    logic signed [DATA_WIDTH-1:0]    r_y0;
    logic signed [ANGLE_WIDTH-1:0]   r_z0;
    logic                            r_core_start;

    assign in_ready = ~w_fifo_full;
    assign w_push   = in_valid & ~w_fifo_full;

    cordic_operand_fifo #(
        .WIDTH (2 * DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   ({in_x, in_y}),
        .o_dout  (w_fifo_dout),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign w_pop_x = w_fifo_dout[2*DATA_WIDTH-1:DATA_WIDTH];
    assign w_pop_y = w_fifo_dout[DATA_WIDTH-1:0];

    // Rotate left-half-plane operands by -/+pi/2 so the core always sees x >= 0.
    always_comb begin
        w_rot_x = w_pop_x;
        w_rot_y = w_pop_y;
        w_rot_z = '0;
        if (w_pop_x < 0) begin
            if (w_pop_y >= 0) begin
                w_rot_x = w_pop_y;
                w_rot_y = DATA_WIDTH'(sat_neg(32'(w_pop_x), DATA_WIDTH));
                w_rot_z = L_PI_2;
            end else begin
                w_rot_x = DATA_WIDTH'(sat_neg(32'(w_pop_y), DATA_WIDTH));
                w_rot_y = w_pop_x;
                w_rot_z = L_NEG_PI_2;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_READY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // DRAIN covers the core's FINAL->IDLE step, where a start would be dropped.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            ST_READY: begin
                if (!w_fifo_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_ARMED;
                end
            end
            ST_ARMED: if (!core_done) w_state_nxt = ST_BUSY;
            ST_BUSY:  if (core_done)  w_state_nxt = ST_DRAIN;
            ST_DRAIN: w_state_nxt = ST_READY;
            default:  w_state_nxt = ST_READY;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_core_start <= 1'b0;
            r_x0         <= '0;
            r_y0         <= '0;
            r_z0         <= '0;
        end else begin
            r_core_start <= w_pop;
            if (w_pop) begin
                r_x0 <= w_rot_x;
                r_y0 <= w_rot_y;
                r_z0 <= w_rot_z;
            end
        end
    end

    assign core_start = r_core_start;
    assign x0         = r_x0;
    assign y0         = r_y0;
    assign z0         = r_z0;
    assign busy       = (r_state != ST_READY);

endmodule

// File: tb/tb_cordic_input_stage.sv
// Directed bench for cordic_input_stage with a 16-iteration core model.
module tb_cordic_input_stage;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] in_x;
    logic signed [15:0] in_y;
    logic               core_done;
    logic               core_start;
    logic signed [15:0] x0;
    logic signed [15:0] y0;
    logic signed [15:0] z0;
    logic               busy;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    cordic_input_stage #(
        .DATA_WIDTH  (16),
        .ANGLE_WIDTH (16),
        .FIFO_DEPTH  (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_x       (in_x),
        .in_y       (in_y),
        .core_done  (core_done),
        .core_start (core_start),
        .x0         (x0),
        .y0         (y0),
        .z0         (z0),
        .busy       (busy)
    );

    // Core model: IDLE(done) -> COMPUTE for 16 cycles -> FINAL(done) -> IDLE.
    logic [1:0] c_state;
    int         c_cnt;
    logic       stall;

    assign core_done = (c_state != 2'd1);

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            c_state <= 2'd0;
            c_cnt   <= 0;
        end else begin
            case (c_state)
                2'd0: if (core_start) begin c_state <= 2'd1; c_cnt <= 0; end
                2'd1: if (!stall) begin
                    if (c_cnt == 15) c_state <= 2'd2;
                    else             c_cnt   <= c_cnt + 1;
                end
                default: c_state <= 2'd0;
            endcase
        end
    end

    // Start monitor: records issued seeds and flags protocol violations.
    logic signed [15:0] q_x[$];
    logic signed [15:0] q_y[$];
    logic signed [15:0] q_z[$];
    int                 q_c[$];
    int                 cyc = 0;
    int                 viol = 0;
    logic               prev_start = 1'b0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        prev_start <= rst && core_start;
        if (rst && core_start) begin
            if (!core_done || c_state == 2'd2 || prev_start) viol <= viol + 1;
            q_x.push_back(x0);
            q_y.push_back(y0);
            q_z.push_back(z0);
            q_c.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic signed [15:0] x, input logic signed [15:0] y);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_x = x;
        in_y = y;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("send_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_starts(input int n, input string tag);
        int k;
        k = 0;
        while (q_x.size() < n && k < 1000) begin
            @(negedge clk);
            k++;
        end
        chk(tag, q_x.size(), n);
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while ((busy || c_state != 2'd0) && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk(tag, busy, 0);
    endtask

    // Holds in_valid high over four operands (x_base*(i+1), i+1).
    task automatic hold_push(input int x_base, output int accepted);
        logic take;
        accepted = 0;
        in_valid = 1'b1;
        in_x = 16'(x_base);
        in_y = 16'sd1;
        repeat (10) begin
            take = in_valid && in_ready;
            @(negedge clk);
            if (take) begin
                accepted++;
                if (accepted < 4) begin
                    in_x = 16'(x_base * (accepted + 1));
                    in_y = 16'(accepted + 1);
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        in_valid = 1'b0;
    endtask

    initial begin
        int acc;
        int nst;
        in_valid = 1'b0;
        in_x = '0;
        in_y = '0;
        stall = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_start", core_start, 0);
        chk("rst_x0", x0, 0);
        chk("rst_y0", y0, 0);
        chk("rst_z0", z0, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);

        send(16'sd100, 16'sd50);
        chk("lat_early_start", core_start, 0);
        @(negedge clk);
        chk("lat_start", core_start, 1);
        chk("q1_x0", x0, 100);
        chk("q1_y0", y0, 50);
        chk("q1_z0", z0, 0);

        send(-16'sd100, 16'sd50);
        send(-16'sd100, -16'sd50);
        send(16'sd0, -16'sd7);
        send(-16'sd32768, 16'sd0);
        send(-16'sd1, -16'sd32768);
        wait_starts(6, "quad_starts");
        chk("q2_x0", q_x[1], 50);
        chk("q2_y0", q_y[1], 100);
        chk("q2_z0", q_z[1], 16384);
        chk("q3_x0", q_x[2], 50);
        chk("q3_y0", q_y[2], -100);
        chk("q3_z0", q_z[2], -16384);
        chk("q4_x0", q_x[3], 0);
        chk("q4_y0", q_y[3], -7);
        chk("q4_z0", q_z[3], 0);
        chk("sat1_x0", q_x[4], 0);
        chk("sat1_y0", q_y[4], 32767);
        chk("sat1_z0", q_z[4], 16384);
        chk("sat2_x0", q_x[5], 32767);
        chk("sat2_y0", q_y[5], -1);
        chk("sat2_z0", q_z[5], -16384);
        for (int i = 1; i < 6; i++) chk($sformatf("gap_%0d", i), q_c[i] - q_c[i-1], 20);
        wait_idle("idle_1");

        stall = 1'b1;
        hold_push(11, acc);
        chk("hs_accepted", acc, 3);
        chk("hs_in_ready", in_ready, 0);
        chk("hs_busy", busy, 1);
        chk("hs_starts", q_x.size(), 7);
        chk("hs_first", q_x[6], 11);
        stall = 1'b0;
        wait_starts(9, "hs_all_starts");
        chk("hs_order2", q_x[7], 22);
        chk("hs_order3", q_x[8], 33);
        chk("hs_order3_y", q_y[8], 3);
        chk("hs_gap", q_c[8] - q_c[7], 20);
        wait_idle("idle_2");

        stall = 1'b1;
        hold_push(5, acc);
        chk("rb_accepted", acc, 3);
        chk("rb_busy_before", busy, 1);
        chk("rb_x0_before", x0, 5);
        rst = 1'b0;
        @(negedge clk);
        chk("rb_busy", busy, 0);
        chk("rb_start", core_start, 0);
        chk("rb_x0", x0, 0);
        chk("rb_y0", y0, 0);
        chk("rb_z0", z0, 0);
        rst = 1'b1;
        stall = 1'b0;
        nst = q_x.size();
        repeat (40) @(negedge clk);
        chk("rb_no_start", q_x.size(), nst);
        chk("rb_busy_after", busy, 0);
        chk("rb_in_ready", in_ready, 1);

        send(-16'sd7, 16'sd3);
        wait_starts(nst + 1, "post_rst_start");
        chk("post_x0", q_x[nst], 3);
        chk("post_y0", q_y[nst], 7);
        chk("post_z0", q_z[nst], 16384);
        wait_idle("idle_3");
        chk("protocol_viol", viol, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1);
    end

endmodule
